// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - central stall/flush/redirect controller for the 5-stage core
// Combinational per-cycle controls plus a 4-state sequencer for redirect, multi-cycle and bus hold.
module pipe_ctrl #(
  parameter int unsigned JUMP_FLUSH_EXTRA = 1,
  parameter int unsigned MC_TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        id_hold_flag_i,
  input  logic        ex_jump_flag_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        mc_start_i,
  input  logic        mc_done_i,
  input  logic        hold_req_i,
  output logic        hold_ack_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic [4:0]  stall_o,
  output logic [4:0]  flush_o,
  output logic        mc_timeout_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {RUN, REDIRECT, MC_WAIT, BUS_HOLD} state_t;

  localparam logic [15:0] REDIR_LOAD = 16'(JUMP_FLUSH_EXTRA);
  localparam logic [15:0] MC_LAST    = 16'(MC_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        hold_ack;
  logic [31:0] stall_cnt;
  logic        jump, timeout;
  logic [4:0]  stall, flush;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    jump      = 1'b0;
    stall     = 5'b00000;
    flush     = 5'b00000;
    timeout   = 1'b0;
    case (state)
      RUN: begin
        if (ex_jump_flag_i) begin
          jump  = 1'b1;
          flush = 5'b00110;
          if (REDIR_LOAD != 16'd0) begin
            state_nxt = REDIRECT;
            cnt_nxt   = REDIR_LOAD;
          end
        end else if (mc_start_i) begin
          stall     = 5'b00111;
          flush     = 5'b01000;
          state_nxt = MC_WAIT;
          cnt_nxt   = 16'd0;
        end else if (id_hold_flag_i) begin
          stall = 5'b00011;
          flush = 5'b00100;
        end else if (hold_req_i) begin
          state_nxt = BUS_HOLD;
        end
      end
      REDIRECT: begin
        // ex is being flushed here, so only a fresh redirect is honoured
        if (ex_jump_flag_i) begin
          jump    = 1'b1;
          flush   = 5'b00110;
          cnt_nxt = REDIR_LOAD;
        end else begin
          flush = 5'b00010;
          if (cnt <= 16'd1) state_nxt = RUN;
          else              cnt_nxt   = cnt - 16'd1;
        end
      end
      MC_WAIT: begin
        if (mc_done_i) begin
          state_nxt = RUN;
        end else if (cnt == MC_LAST) begin
          timeout   = 1'b1;
          state_nxt = RUN;
        end else begin
          stall   = 5'b00111;
          flush   = 5'b01000;
          cnt_nxt = cnt + 16'd1;
        end
      end
      BUS_HOLD: begin
        stall = 5'b11111;
        if (!hold_req_i) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state     <= RUN;
      cnt       <= 16'd0;
      hold_ack  <= 1'b0;
      stall_cnt <= 32'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hold_ack <= (state_nxt == BUS_HOLD);
      if (stall[0]) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Combinational outputs are gated so nothing leaks out while reset is held
  assign jump_flag_o  = jump & ~rstn;
  assign jump_addr_o  = (jump & ~rstn) ? ex_jump_addr_i : 32'd0;
  assign stall_o      = rstn ? 5'b00000 : stall;
  assign flush_o      = rstn ? 5'b00000 : flush;
  assign mc_timeout_o = timeout & ~rstn;
  assign hold_ack_o   = hold_ack;
  assign stall_cnt_o  = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
// Directed vector table, hand sequences for multi-cycle corners, randomized run against a model.
module tb_pipe_ctrl;

  localparam int JFE = 2;
  localparam int MCT = 64;

  logic        clk = 1'b0;
  logic        rstn;
  logic        id_hold, ex_jump, mc_start, mc_done, hold_req;
  logic [31:0] ex_addr;

  logic        hold_ack, jump_flag, mc_to;
  logic [31:0] jump_addr, stall_cnt;
  logic [4:0]  stall, flush;

  logic        t_hold_ack, t_jump_flag, t_mc_to;
  logic [31:0] t_jump_addr, t_stall_cnt;
  logic [4:0]  t_stall, t_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.JUMP_FLUSH_EXTRA(JFE), .MC_TIMEOUT(MCT)) dut (
    .clk(clk), .rstn(rstn), .id_hold_flag_i(id_hold), .ex_jump_flag_i(ex_jump),
    .ex_jump_addr_i(ex_addr), .mc_start_i(mc_start), .mc_done_i(mc_done),
    .hold_req_i(hold_req), .hold_ack_o(hold_ack), .jump_flag_o(jump_flag),
    .jump_addr_o(jump_addr), .stall_o(stall), .flush_o(flush),
    .mc_timeout_o(mc_to), .stall_cnt_o(stall_cnt)
  );

  pipe_ctrl #(.JUMP_FLUSH_EXTRA(JFE), .MC_TIMEOUT(8)) dut_t (
    .clk(clk), .rstn(rstn), .id_hold_flag_i(id_hold), .ex_jump_flag_i(ex_jump),
    .ex_jump_addr_i(ex_addr), .mc_start_i(mc_start), .mc_done_i(mc_done),
    .hold_req_i(hold_req), .hold_ack_o(t_hold_ack), .jump_flag_o(t_jump_flag),
    .jump_addr_o(t_jump_addr), .stall_o(t_stall), .flush_o(t_flush),
    .mc_timeout_o(t_mc_to), .stall_cnt_o(t_stall_cnt)
  );

  // ins = {jump, mc_start, mc_done, id_hold, hold_req}; eflags = {jump_flag, hold_ack, mc_timeout}
  typedef struct {
    logic [4:0]  ins;
    logic [31:0] addr;
    logic [2:0]  eflags;
    logic [31:0] e_addr;
    logic [4:0]  e_stall;
    logic [4:0]  e_flush;
    logic [31:0] e_scnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [4:0] ins, input logic [31:0] addr,
                              input logic [2:0] eflags, input logic [31:0] e_addr,
                              input logic [4:0] e_stall, input logic [4:0] e_flush,
                              input logic [31:0] e_scnt);
    vec_t v;
    v.ins = ins; v.addr = addr; v.eflags = eflags; v.e_addr = e_addr;
    v.e_stall = e_stall; v.e_flush = e_flush; v.e_scnt = e_scnt;
    return v;
  endfunction

  task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s actual=%h required=%h", name, field, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] ins, input logic [31:0] addr);
    {ex_jump, mc_start, mc_done, id_hold, hold_req} = ins;
    ex_addr = addr;
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    drive(v.ins, v.addr);
    #3;
    chk(name, "jump_flag", 32'(jump_flag), 32'(v.eflags[2]));
    chk(name, "jump_addr", jump_addr, v.e_addr);
    chk(name, "stall", 32'(stall), 32'(v.e_stall));
    chk(name, "flush", 32'(flush), 32'(v.e_flush));
    chk(name, "hold_ack", 32'(hold_ack), 32'(v.eflags[1]));
    chk(name, "mc_timeout", 32'(mc_to), 32'(v.eflags[0]));
    chk(name, "stall_cnt", stall_cnt, v.e_scnt);
    @(posedge clk); #1;
  endtask

  // Reference model: remaining flush cycles, multi-cycle age and hold grant
  int          m_red, m_age;
  bit          m_mc, m_held;
  logic [31:0] m_scnt;

  task automatic model_cycle(input int n);
    logic        ej, eto, eack;
    logic [31:0] ea;
    logic [4:0]  es, ef;
    string       name;
    ej = 1'b0; ea = 32'd0; es = 5'd0; ef = 5'd0; eto = 1'b0; eack = m_held;
    if (m_held) begin
      es = 5'b11111;
      if (!hold_req) m_held = 1'b0;
    end else if (m_mc) begin
      if (mc_done) m_mc = 1'b0;
      else if (m_age == MCT - 1) begin eto = 1'b1; m_mc = 1'b0; end
      else begin es = 5'b00111; ef = 5'b01000; m_age++; end
    end else if (ex_jump) begin
      ej = 1'b1; ea = ex_addr; ef = 5'b00110; m_red = JFE;
    end else if (m_red > 0) begin
      ef = 5'b00010; m_red--;
    end else if (mc_start) begin
      es = 5'b00111; ef = 5'b01000; m_mc = 1'b1; m_age = 0;
    end else if (id_hold) begin
      es = 5'b00011; ef = 5'b00100;
    end else if (hold_req) begin
      m_held = 1'b1;
    end
    name = $sformatf("rnd%0d", n);
    chk(name, "jump_flag", 32'(jump_flag), 32'(ej));
    chk(name, "jump_addr", jump_addr, ea);
    chk(name, "stall", 32'(stall), 32'(es));
    chk(name, "flush", 32'(flush), 32'(ef));
    chk(name, "hold_ack", 32'(hold_ack), 32'(eack));
    chk(name, "mc_timeout", 32'(mc_to), 32'(eto));
    chk(name, "stall_cnt", stall_cnt, m_scnt);
    if (es[0]) m_scnt = m_scnt + 32'd1;
  endtask

  initial begin
    logic [31:0] sc;
    logic [4:0]  rins;

    tbl.push_back(mk(5'b00000, 32'h0,        3'b000, 32'h0,   5'b00000, 5'b00000, 32'd0));
    tbl.push_back(mk(5'b00010, 32'h0,        3'b000, 32'h0,   5'b00011, 5'b00100, 32'd0));
    tbl.push_back(mk(5'b00000, 32'h0,        3'b000, 32'h0,   5'b00000, 5'b00000, 32'd1));
    tbl.push_back(mk(5'b10000, 32'h100,      3'b100, 32'h100, 5'b00000, 5'b00110, 32'd1));
    tbl.push_back(mk(5'b00000, 32'hdeadbeef, 3'b000, 32'h0,   5'b00000, 5'b00010, 32'd1));
    tbl.push_back(mk(5'b00000, 32'h0,        3'b000, 32'h0,   5'b00000, 5'b00010, 32'd1));
    tbl.push_back(mk(5'b00000, 32'hffffffff, 3'b000, 32'h0,   5'b00000, 5'b00000, 32'd1));
    tbl.push_back(mk(5'b10000, 32'h100,      3'b100, 32'h100, 5'b00000, 5'b00110, 32'd1));
    tbl.push_back(mk(5'b10000, 32'h200,      3'b100, 32'h200, 5'b00000, 5'b00110, 32'd1));
    tbl.push_back(mk(5'b00000, 32'h0,        3'b000, 32'h0,   5'b00000, 5'b00010, 32'd1));
    tbl.push_back(mk(5'b00000, 32'h0,        3'b000, 32'h0,   5'b00000, 5'b00010, 32'd1));
    tbl.push_back(mk(5'b00000, 32'h0,        3'b000, 32'h0,   5'b00000, 5'b00000, 32'd1));
    tbl.push_back(mk(5'b11010, 32'h300,      3'b100, 32'h300, 5'b00000, 5'b00110, 32'd1));
    tbl.push_back(mk(5'b01000, 32'h0,        3'b000, 32'h0,   5'b00000, 5'b00010, 32'd1));
    tbl.push_back(mk(5'b00001, 32'h0,        3'b000, 32'h0,   5'b00000, 5'b00010, 32'd1));
    tbl.push_back(mk(5'b00000, 32'h0,        3'b000, 32'h0,   5'b00000, 5'b00000, 32'd1));
    tbl.push_back(mk(5'b00001, 32'h0,        3'b000, 32'h0,   5'b00000, 5'b00000, 32'd1));
    tbl.push_back(mk(5'b00001, 32'h0,        3'b010, 32'h0,   5'b11111, 5'b00000, 32'd1));
    tbl.push_back(mk(5'b00001, 32'h0,        3'b010, 32'h0,   5'b11111, 5'b00000, 32'd2));
    tbl.push_back(mk(5'b00001, 32'h0,        3'b010, 32'h0,   5'b11111, 5'b00000, 32'd3));
    tbl.push_back(mk(5'b00001, 32'h0,        3'b010, 32'h0,   5'b11111, 5'b00000, 32'd4));
    tbl.push_back(mk(5'b00000, 32'h0,        3'b010, 32'h0,   5'b11111, 5'b00000, 32'd5));
    tbl.push_back(mk(5'b00000, 32'h0,        3'b000, 32'h0,   5'b00000, 5'b00000, 32'd6));

    // Reset with every request raised: all outputs must stay 0
    rstn = 1'b1;
    drive(5'b11011, 32'hdead0000);
    @(posedge clk); @(posedge clk); #3;
    chk("reset", "jump_flag", 32'(jump_flag), 32'd0);
    chk("reset", "jump_addr", jump_addr, 32'd0);
    chk("reset", "stall", 32'(stall), 32'd0);
    chk("reset", "flush", 32'(flush), 32'd0);
    chk("reset", "hold_ack", 32'(hold_ack), 32'd0);
    chk("reset", "mc_timeout", 32'(mc_to), 32'd0);
    chk("reset", "stall_cnt", stall_cnt, 32'd0);
    @(posedge clk); #1;
    drive(5'b00000, 32'h0);
    rstn = 1'b0;

    foreach (tbl[i]) apply_vec(tbl[i], $sformatf("tbl%0d", i));

    // Multi-cycle op: start, ignored jump/load-use while waiting, done together with start
    sc = 32'd6;
    for (int k = 0; k <= 11; k++) begin
      vec_t v;
      logic [4:0] ins;
      ins = (k == 0) ? 5'b01000 : (k == 3) ? 5'b10000 : (k == 5) ? 5'b00010 :
            (k == 10) ? 5'b01100 : 5'b00000;
      if (k < 10) v = mk(ins, 32'h400, 3'b000, 32'h0, 5'b00111, 5'b01000, sc);
      else        v = mk(ins, 32'h400, 3'b000, 32'h0, 5'b00000, 5'b00000, sc);
      apply_vec(v, $sformatf("mc%0d", k));
      if (k < 10) sc = sc + 32'd1;
    end

    // Reset asserted in the middle of a bus hold
    drive(5'b00001, 32'h0);
    @(posedge clk); #1;
    #2;
    chk("rst_hold", "hold_ack_before", 32'(hold_ack), 32'd1);
    drive(5'b10001, 32'h500);
    rstn = 1'b1;
    #1;
    chk("rst_hold", "hold_ack", 32'(hold_ack), 32'd0);
    chk("rst_hold", "stall", 32'(stall), 32'd0);
    chk("rst_hold", "flush", 32'(flush), 32'd0);
    chk("rst_hold", "jump_flag", 32'(jump_flag), 32'd0);
    chk("rst_hold", "jump_addr", jump_addr, 32'd0);
    chk("rst_hold", "stall_cnt", stall_cnt, 32'd0);
    @(posedge clk); #1;
    drive(5'b00000, 32'h0);
    rstn = 1'b0;

    // Timeout on the MC_TIMEOUT=8 instance: pulse in cycle 8 after the start
    for (int k = 0; k <= 9; k++) begin
      drive((k == 0) ? 5'b01000 : 5'b00000, 32'h0);
      #3;
      chk($sformatf("to%0d", k), "mc_timeout", 32'(t_mc_to), (k == 8) ? 32'd1 : 32'd0);
      chk($sformatf("to%0d", k), "stall", 32'(t_stall), (k < 8) ? 32'd7 : 32'd0);
      chk($sformatf("to%0d", k), "flush", 32'(t_flush), (k < 8) ? 32'd8 : 32'd0);
      @(posedge clk); #1;
    end

    // Randomized run against the model, with a stretch of no done pulses to force timeouts
    rstn = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
    m_red = 0; m_age = 0; m_mc = 1'b0; m_held = 1'b0; m_scnt = 32'd0;
    rins = 5'b00000;
    for (int n = 0; n < 600; n++) begin
      rins[4] = ($urandom_range(0, 7) == 0);
      rins[3] = ($urandom_range(0, 7) == 0);
      rins[2] = (n >= 250 && n < 400) ? 1'b0 : ($urandom_range(0, 5) == 0);
      rins[1] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) rins[0] = ~rins[0];
      drive(rins, $urandom);
      #3;
      model_cycle(n);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core (if, if_id, id, id_ex, ex, ex_mem, mem, mem_wb).
- Collects hazard and redirect requests from id (load-use hold), ex (taken branch/jump, multi-cycle op) and an external bus master.
- Issues per-stage stall and flush vectors, plus the PC redirect.
- Sequences multi-cycle redirect flushes, multi-cycle execute waits and bus-hold handshakes with a 4-state FSM, and counts stall cycles.

Parameters:
- JUMP_FLUSH_EXTRA, 1, extra cycles the if_id flush is held after a redirect (fetch latency); 0..15.
- MC_TIMEOUT, 64, maximum MC_WAIT cycles before forced abort; 2..65535.

Ports:
- clk  in  1  core clock, rising edge.
- rstn  in  1  reset, asynchronous, active-high (asserted = 1).
- id_hold_flag_i  in  1  load-use hazard from id.
- ex_jump_flag_i  in  1  taken branch/jal/jalr resolved in ex.
- ex_jump_addr_i  in  32  redirect target.
- mc_start_i  in  1  ex starts a multi-cycle op (pulse).
- mc_done_i  in  1  multi-cycle result valid (pulse).
- hold_req_i  in  1  external bus hold request (level).
- hold_ack_o  out  1  hold granted, pipeline frozen.
- jump_flag_o  out  1  PC load enable.
- jump_addr_o  out  32  PC load value.
- stall_o  out  5  stall per stage: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb.
- flush_o  out  5  bubble insert, same bit map; bit 0 unused (0).
- mc_timeout_o  out  1  one-cycle pulse on MC abort.
- stall_cnt_o  out  32  cycles with stall_o[0]=1.

Behaviour:
- Reset:
  - FSM = RUN, redirect counter = 0, MC counter = 0, stall_cnt_o = 0.
  - All outputs 0 while rstn = 1, including any combinational outputs.
  - Reset mid-operation aborts immediately; hold_ack_o drops asynchronously.
- FSM states: RUN, REDIRECT, MC_WAIT, BUS_HOLD.
- RUN priority: jump > mc_start > load-use > hold_req.
  - ex_jump_flag_i:
    - Same cycle (combinational): jump_flag_o = 1, jump_addr_o = ex_jump_addr_i, flush_o = 5'b00110.
    - If JUMP_FLUSH_EXTRA > 0, go to REDIRECT with counter = JUMP_FLUSH_EXTRA.
  - mc_start_i: stall_o = 5'b00111, flush_o = 5'b01000; go to MC_WAIT, counter = 0.
  - id_hold_flag_i: stall_o = 5'b00011, flush_o = 5'b00100 for that cycle only; no state change.
  - hold_req_i: go to BUS_HOLD; hold_ack_o is registered, so it rises the cycle after the request is seen.
- REDIRECT:
  - flush_o[1] = 1 each cycle; counter decrements; return to RUN when counter reaches 1.
  - A new ex_jump_flag_i here restarts the counter, with the new target driven the same cycle.
  - mc_start_i and hold_req_i are ignored in this state (ex contents are being flushed).
- MC_WAIT:
  - stall_o = 5'b00111, flush_o = 5'b01000 every cycle.
  - mc_done_i: release the stall the same cycle; go to RUN.
  - Counter reaches MC_TIMEOUT−1 without mc_done_i: pulse mc_timeout_o, release, go to RUN.
  - ex_jump_flag_i and id_hold_flag_i are ignored.
- BUS_HOLD:
  - hold_ack_o = 1, stall_o = 5'b11111, flush_o = 0.
  - hold_req_i = 0: hold_ack_o clears the next cycle (registered); go to RUN.
- jump_addr_o = 0 whenever jump_flag_o = 0.
- stall_cnt_o increments on every cycle with stall_o[0] = 1 (including BUS_HOLD) and wraps 0xFFFFFFFF → 0.
- Simultaneous mc_done_i and mc_start_i: done has effect, start ignored (ex is stalled).

Test Plan:
- Load-use:
  - Stimulus: id_hold_flag_i = 1 for one cycle in RUN.
  - Required: stall_o = 00011, flush_o = 00100 that cycle only; stall_cnt_o = 1 afterwards.
- Jump, JUMP_FLUSH_EXTRA = 2:
  - Stimulus: ex_jump_flag_i = 1 with addr 0x0000_0100.
  - Required: jump_flag_o = 1 and jump_addr_o = 0x100 that cycle, flush_o = 00110; then 2 cycles with flush_o = 00010; then RUN.
- Back-to-back jumps:
  - Stimulus: second jump (0x200) in the first REDIRECT cycle.
  - Required: jump_addr_o = 0x200 that cycle; flush extends 2 more cycles.
- Multi-cycle op:
  - Stimulus: mc_start_i, then mc_done_i 10 cycles later.
  - Required: stall_o = 00111 for 10 cycles, released on the done cycle, mc_timeout_o = 0.
  - Repeat with no done and MC_TIMEOUT = 8: mc_timeout_o pulses in cycle 8, then RUN.
- Bus hold:
  - Stimulus: hold_req_i rises, held for 5 cycles.
  - Required: hold_ack_o = 1 from the next cycle, stall_o = 11111; ack drops one cycle after the request falls.
  - Assert rstn mid-hold: ack = 0 immediately, all outputs 0.
- Priority:
  - Stimulus: ex_jump_flag_i, mc_start_i and id_hold_flag_i asserted in the same cycle.
  - Required: jump behaviour only (flush_o = 00110), FSM not in MC_WAIT.
